// File: rtl/hit_log_pkg.sv
// Shared constants and helpers for the hit timestamp logger.
package hit_log_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

    // One extra pointer bit distinguishes full from empty when the indices match.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hit_timestamp_fifo_if.sv
// Host-side read port of the hit timestamp FIFO (valid/ready with head data).
interface hit_timestamp_fifo_if #(
    parameter int TS_W = 16
);
    logic            rd_valid;
    logic            rd_ready;
    logic [TS_W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO with wrap-bit pointers.
module sync_fifo
    import hit_log_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          wdata,
    output logic                      full,
    output logic                      empty,
    output logic [ptr_width(DEPTH)-1:0] level,
    output logic [WIDTH-1:0]          head
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign level = wptr - rptr;
    assign head  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/hit_timestamp_fifo.sv
// Stamps detector hits with a free-running cycle count and queues them for a host.
module hit_timestamp_fifo
    import hit_log_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hit_in,
    hit_timestamp_fifo_if.master     rd,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         hit_count,
    output logic                     overflow
);

    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] head;
    logic            full;
    logic            empty;
    logic            pop;
    logic            push;

    always_ff @(posedge clk) begin
        if (rst) ts <= '0;
        else     ts <= ts + 1'b1;
    end

    // A full FIFO still takes a hit when the head leaves on the same edge.
    assign pop  = !empty && rd.rd_ready;
    assign push = hit_in && (!full || pop);

    sync_fifo #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (ts),
        .full  (full),
        .empty (empty),
        .level (level),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (hit_in && (hit_count != '1)) hit_count <= hit_count + 1'b1;
            if (hit_in && !push)             overflow  <= 1'b1;
        end
    end

    assign rd.rd_valid = !empty;
    assign rd.rd_data  = empty ? '0 : head;

endmodule
